// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared definitions for the Spartan-3E character LCD path: the byte-writer
//   state encoding and the default 50 MHz cycle counts. The init FSM uses the
//   long power-on waits defined here.
//   No ports (package).
package lcd_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SETUP_H = 4'd1,
    S_PULSE_H = 4'd2,
    S_HOLD_H  = 4'd3,
    S_GAP_N   = 4'd4,
    S_SETUP_L = 4'd5,
    S_PULSE_L = 4'd6,
    S_HOLD_L  = 4'd7,
    S_GAP_B   = 4'd8
  } lcd_state_t;

  // Byte-writer timing at 50 MHz (20 ns per cycle)
  localparam int T_SETUP_DEF      = 2;     // 40 ns
  localparam int T_EPULSE_DEF     = 12;    // 240 ns
  localparam int T_HOLD_DEF       = 1;     // 20 ns
  localparam int T_NIBBLE_GAP_DEF = 50;    // 1 us
  localparam int T_BYTE_GAP_DEF   = 2000;  // 40 us

  // Power-on init waits, same clock
  localparam int T_INIT_15MS      = 750000;
  localparam int T_INIT_4MS1      = 205000;
  localparam int T_INIT_100US     = 5000;

  function automatic int max_of5(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter
//   Down-counter for timed FSM states. A start pulse loads N-1; done is high
//   in the last of the N cycles so the FSM can advance on the following edge.
//   A start in the done cycle reloads for the next state without a gap.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-low
//   start  in  load the counter and begin timing
//   load   in  W  value to load (state length minus one)
//   done   out high during the final cycle of the timed interval
module lcd_delay_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         active;

  always_ff @(posedge clk) begin
    if (!reset) begin
      active <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
    end else if (active && (cnt == '0)) begin
      active <= 1'b0;
    end
  end

  // Count value is only meaningful while active, so it needs no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      cnt <= load;
    end else if (active && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = active && (cnt == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer
//   4-bit-mode HD44780 physical writer. Takes one byte (or one init nibble)
//   per valid/ready handshake and sequences SF_D, LCD_E and LCD_RS with
//   setup / pulse / hold / gap timing. Each timed state lasts exactly its
//   parameter in cycles (all parameters must be >= 1).
// Ports:
//   clk            in  50 MHz clock
//   reset          in  synchronous, active-low
//   in_valid       in  upstream offers a transfer
//   in_ready       out high only while idle
//   in_rs          in  0 = command, 1 = character data
//   in_byte        in  8  byte to send ([3:0] only for nibble-only)
//   in_nibble_only in  send in_byte[3:0] as a single nibble
//   busy           out transfer in progress (~in_ready)
//   LCD_RS         out register select
//   LCD_RW         out tied low, write only
//   LCD_E          out enable strobe
//   SF_D           out 4  data nibble (board pins SF_D[11:8])
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP      = T_SETUP_DEF,
  parameter int T_EPULSE     = T_EPULSE_DEF,
  parameter int T_HOLD       = T_HOLD_DEF,
  parameter int T_NIBBLE_GAP = T_NIBBLE_GAP_DEF,
  parameter int T_BYTE_GAP   = T_BYTE_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_byte,
  input  logic       in_nibble_only,
  output logic       busy,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [3:0] SF_D
);

  localparam int CNT_W = $clog2(max_of5(T_SETUP, T_EPULSE, T_HOLD,
                                        T_NIBBLE_GAP, T_BYTE_GAP) + 1);

  localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_EPULSE = CNT_W'(T_EPULSE - 1);
  localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_NGAP   = CNT_W'(T_NIBBLE_GAP - 1);
  localparam logic [CNT_W-1:0] L_BGAP   = CNT_W'(T_BYTE_GAP - 1);

  lcd_state_t       state, state_next;
  logic             cnt_start, cnt_done;
  logic [CNT_W-1:0] cnt_load;
  logic             accept;
  logic [7:0]       byte_cap;
  logic             rs_cap;
  logic             ready_q;

  assign accept = in_valid && (state == S_IDLE);

  lcd_delay_counter #(.W(CNT_W)) u_delay (
    .clk   (clk),
    .reset (reset),
    .start (cnt_start),
    .load  (cnt_load),
    .done  (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every state change into a timed state also starts the counter for it.
  always_comb begin
    state_next = state;
    cnt_start  = 1'b0;
    cnt_load   = '0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_next = in_nibble_only ? S_SETUP_L : S_SETUP_H;
          cnt_start  = 1'b1;
          cnt_load   = L_SETUP;
        end
      end
      S_SETUP_H: if (cnt_done) begin
        state_next = S_PULSE_H; cnt_start = 1'b1; cnt_load = L_EPULSE;
      end
      S_PULSE_H: if (cnt_done) begin
        state_next = S_HOLD_H;  cnt_start = 1'b1; cnt_load = L_HOLD;
      end
      S_HOLD_H: if (cnt_done) begin
        state_next = S_GAP_N;   cnt_start = 1'b1; cnt_load = L_NGAP;
      end
      S_GAP_N: if (cnt_done) begin
        state_next = S_SETUP_L; cnt_start = 1'b1; cnt_load = L_SETUP;
      end
      S_SETUP_L: if (cnt_done) begin
        state_next = S_PULSE_L; cnt_start = 1'b1; cnt_load = L_EPULSE;
      end
      S_PULSE_L: if (cnt_done) begin
        state_next = S_HOLD_L;  cnt_start = 1'b1; cnt_load = L_HOLD;
      end
      S_HOLD_L: if (cnt_done) begin
        state_next = S_GAP_B;   cnt_start = 1'b1; cnt_load = L_BGAP;
      end
      S_GAP_B: if (cnt_done) begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      byte_cap <= in_byte;
      rs_cap   <= in_rs;
    end
  end

  // Pins are registered from the current state, so they trail the state by
  // one cycle; relative setup/pulse/hold lengths are unaffected. SF_D and RS
  // keep their last value through the byte gap and idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_q <= 1'b1;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      SF_D    <= 4'h0;
    end else begin
      ready_q <= (state_next == S_IDLE);
      LCD_E   <= (state == S_PULSE_H) || (state == S_PULSE_L);
      case (state)
        S_SETUP_H, S_PULSE_H, S_HOLD_H, S_GAP_N: begin
          SF_D   <= byte_cap[7:4];
          LCD_RS <= rs_cap;
        end
        S_SETUP_L, S_PULSE_L, S_HOLD_L: begin
          SF_D   <= byte_cap[3:0];
          LCD_RS <= rs_cap;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = ready_q;
  assign busy     = ~ready_q;
  assign LCD_RW   = 1'b0;

endmodule
